// File: rtl/ram_data_port_ctrl.sv
// Requester-side controller for the RAM_data simple-dual-port memory: turns load/store requests
// into RAM port activity and returns load data in order. Define PERF_CNT_EN to add perf counters.
module ram_data_port_ctrl #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
`ifdef PERF_CNT_EN
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       stall_count,
`endif
  output logic              busy
);

  localparam int unsigned DEPTH = RD_LAT + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1);

  logic              run_q, run_d;
  logic [RD_LAT:0]   vld_q, vld_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] rdaddr_q, rdaddr_d, wraddr_q, wraddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wren_q, wren_d;
  logic [CNT_W-1:0]  inflight;
  logic              ld, st, push, pop;
`ifdef PERF_CNT_EN
  logic [31:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, stall_cnt_q, stall_cnt_d;
`endif

  always_comb begin
    // The valid pipe carries one extra stage beyond RD_LAT so the push samples ram_q one edge
    // after it settles; every stage holds a credit so the FIFO can never be pushed while full.
    inflight = '0;
    for (int unsigned i = 0; i <= RD_LAT; i++) begin
      inflight = inflight + CNT_W'(vld_q[i]);
    end
    req_ready = run_q && ((inflight + cnt_q) < CNT_W'(DEPTH));
    rsp_valid = (cnt_q != '0);
    rsp_rdata = mem_q[rd_ptr_q];
    busy      = (inflight != '0) || rsp_valid;
    ld        = req_valid && req_ready && !req_we;
    st        = req_valid && req_ready && req_we;
    push      = vld_q[RD_LAT];
    pop       = rsp_valid && rsp_ready;

    run_d    = 1'b1;
    vld_d    = {vld_q[RD_LAT-1:0], ld};
    rdaddr_d = ld ? req_addr : rdaddr_q;
    wren_d   = st;
    wraddr_d = st ? req_addr : wraddr_q;
    wdata_d  = st ? req_wdata : wdata_q;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = ram_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);

`ifdef PERF_CNT_EN
    rd_cnt_d    = rd_cnt_q + 32'(ld);
    wr_cnt_d    = wr_cnt_q + 32'(st);
    stall_cnt_d = stall_cnt_q + 32'(req_valid && !req_ready);
`endif
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdaddr_q <= '0;
      wraddr_q <= '0;
      wdata_q  <= '0;
      wren_q   <= 1'b0;
`ifdef PERF_CNT_EN
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
`endif
    end else begin
      run_q    <= run_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      rdaddr_q <= rdaddr_d;
      wraddr_q <= wraddr_d;
      wdata_q  <= wdata_d;
      wren_q   <= wren_d;
`ifdef PERF_CNT_EN
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign ram_rdaddress = rdaddr_q;
  assign ram_wraddress = wraddr_q;
  assign ram_data      = wdata_q;
  assign ram_wren      = wren_q;
`ifdef PERF_CNT_EN
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;
  assign stall_count   = stall_cnt_q;
`endif

endmodule
